// File: rtl/load_store_unit_pkg.sv
// Package: load_store_unit_pkg
// Purpose: shared types, funct3 encodings and decode helpers for the load/store unit.
// Contents: memory_operation_t, lsu_state_t, lsu_fault_t, F3_* width codes,
//           f3_legal() and f3_misaligned() helpers.
package load_store_unit_pkg;

  typedef enum logic [1:0] {MEM_NONE, LOAD_DATA, STORE_DATA} memory_operation_t;
  typedef enum logic [1:0] {LSU_IDLE, LSU_BUS, LSU_RESP} lsu_state_t;
  typedef enum logic [1:0] {FAULT_NONE, FAULT_MISALIGN, FAULT_BUS, FAULT_TIMEOUT} lsu_fault_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // 011, 110 and 111 have no RV32I load/store meaning.
  function automatic logic f3_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // True when the address is not naturally aligned for the access width.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic res;
    res = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) res = a[0];
    else if (f3 == F3_LW)                res = (a != 2'b00);
    return res;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Interface: load_store_unit_if
// Purpose: Wishbone-classic data bus between the load/store unit (master) and memory (slave).
// Signals: wb_cyc_o/wb_stb_o cycle and strobe, wb_we_o write enable, wb_adr_o word address,
//          wb_dat_o store data, wb_sel_o byte enables, wb_dat_i read data,
//          wb_ack_i acknowledge, wb_err_i bus error. Suffixes are from the master's view.
interface load_store_unit_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Module: lsu_lane_align (combinational)
// Purpose: byte-lane steering for the load/store unit.
// Ports: i_funct3    access width/signedness
//        i_addr_lo   address bits [1:0]
//        i_wdata     right-aligned store data
//        i_bus_rdata raw bus read word
//        o_sel       byte enables
//        o_store_data store data replicated across lanes
//        o_load_data selected lane, sign- or zero-extended
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_store_data,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_bus_rdata[{i_addr_lo, 3'b000} +: 8];
    // Halfwords ignore a[0]; a misaligned H is either trapped upstream or rounded down.
    w_half = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    o_sel        = 4'b0000;
    o_store_data = i_wdata;
    o_load_data  = 32'h0;
    case (i_funct3)
      F3_LB, F3_LBU: begin
        o_sel        = 4'b0001 << i_addr_lo;
        o_store_data = {4{i_wdata[7:0]}};
      end
      F3_LH, F3_LHU: begin
        o_sel        = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_store_data = {2{i_wdata[15:0]}};
      end
      F3_LW: begin
        o_sel        = 4'b1111;
        o_store_data = i_wdata;
      end
      default: ;
    endcase

    case (i_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_load_data = {24'h0, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_load_data = {16'h0, w_half};
      F3_LW:   o_load_data = i_bus_rdata;
      default: o_load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Module: load_store_unit
// Purpose: executes one data-memory load or store per start over a Wishbone-classic master
//          port and returns extended load data to the register file; holds the core via
//          o_busy while a bus cycle is open.
// Parameters: TIMEOUT_CYCLES - bus cycles waited for ack/err before aborting (>= 2).
// Build option: LSU_MISALIGN_TRAP_EN - when defined, misaligned H/W accesses complete
//          without a bus cycle and report FAULT_MISALIGN; otherwise low bits are ignored.
// Ports: clk, rst_n (async active-low)
//        i_start, i_mem_op, i_funct3, i_addr, i_wdata - request, sampled only when idle
//        o_busy  - bus cycle in flight
//        o_done  - one-cycle completion pulse; o_rdata/o_fault valid with it
//        o_rdata - extended load data, held until the next accepted start
//        o_fault - completion cause
//        wb      - Wishbone master modport
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  memory_operation_t i_mem_op,
  input  logic [2:0]        i_funct3,
  input  logic [31:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output lsu_fault_t        o_fault,
  load_store_unit_if.master wb
);

  lsu_state_t  r_state, w_state_next;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt, w_cnt_next;
  logic [31:0] r_rdata, w_rdata_next;
  lsu_fault_t  r_fault, w_fault_next;
  logic        w_accept_bus;
  logic        w_reject;
  logic        w_in_bus;

  logic [3:0]  w_sel;
  logic [31:0] w_store_data;
  logic [31:0] w_load_data;

  lsu_lane_align u_lane_align (
    .i_funct3     (r_funct3),
    .i_addr_lo    (r_addr[1:0]),
    .i_wdata      (r_wdata),
    .i_bus_rdata  (wb.wb_dat_i),
    .o_sel        (w_sel),
    .o_store_data (w_store_data),
    .o_load_data  (w_load_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_reject = !f3_legal(i_funct3) || f3_misaligned(i_funct3, i_addr[1:0]);
`else
  assign w_reject = !f3_legal(i_funct3);
`endif

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdata_next = r_rdata;
    w_fault_next = r_fault;
    w_accept_bus = 1'b0;

    unique case (r_state)
      LSU_IDLE: begin
        if (i_start) begin
          w_rdata_next = 32'h0;
          w_fault_next = FAULT_NONE;
          if (i_mem_op == MEM_NONE) begin
            w_state_next = LSU_RESP;
          end else if (w_reject) begin
            w_state_next = LSU_RESP;
            w_fault_next = FAULT_MISALIGN;
          end else begin
            w_state_next = LSU_BUS;
            w_cnt_next   = 32'h0;
            w_accept_bus = 1'b1;
          end
        end
      end
      LSU_BUS: begin
        w_cnt_next = r_cnt + 32'd1;
        // err takes priority over a simultaneous ack.
        if (wb.wb_err_i) begin
          w_state_next = LSU_RESP;
          w_fault_next = FAULT_BUS;
          w_rdata_next = 32'h0;
        end else if (wb.wb_ack_i) begin
          w_state_next = LSU_RESP;
          w_fault_next = FAULT_NONE;
          w_rdata_next = r_we ? 32'h0 : w_load_data;
        end else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
          w_state_next = LSU_RESP;
          w_fault_next = FAULT_TIMEOUT;
          w_rdata_next = 32'h0;
        end
      end
      LSU_RESP: begin
        w_state_next = LSU_IDLE;
      end
      default: begin
        w_state_next = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= LSU_IDLE;
      r_cnt    <= 32'h0;
      r_rdata  <= 32'h0;
      r_fault  <= FAULT_NONE;
      r_we     <= 1'b0;
      r_funct3 <= 3'b000;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rdata <= w_rdata_next;
      r_fault <= w_fault_next;
      // Request fields are captured once and stay frozen for the whole bus cycle.
      if (w_accept_bus) begin
        r_we     <= (i_mem_op == STORE_DATA);
        r_funct3 <= i_funct3;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
      end
    end
  end

  assign w_in_bus    = (r_state == LSU_BUS);
  assign o_busy      = w_in_bus;
  assign o_done      = (r_state == LSU_RESP);
  assign o_rdata     = r_rdata;
  assign o_fault     = r_fault;

  assign wb.wb_cyc_o = w_in_bus;
  assign wb.wb_stb_o = w_in_bus;
  assign wb.wb_we_o  = r_we & w_in_bus;
  assign wb.wb_adr_o = {r_addr[31:2], 2'b00};
  assign wb.wb_dat_o = w_store_data;
  assign wb.wb_sel_o = w_in_bus ? w_sel : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench: tb_load_store_unit
// Purpose: directed checks of the load/store unit with TIMEOUT_CYCLES=4. Inputs are driven
//          and outputs sampled on the falling clock edge.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_start;
  memory_operation_t i_mem_op;
  logic [2:0]        i_funct3;
  logic [31:0]       i_addr;
  logic [31:0]       i_wdata;
  logic              o_busy;
  logic              o_done;
  logic [31:0]       o_rdata;
  lsu_fault_t        o_fault;

  int total = 0;
  int bad   = 0;

  load_store_unit_if bus ();

  load_store_unit #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (i_start),
    .i_mem_op (i_mem_op),
    .i_funct3 (i_funct3),
    .i_addr   (i_addr),
    .i_wdata  (i_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_rdata  (o_rdata),
    .o_fault  (o_fault),
    .wb       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic launch(input memory_operation_t op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
    i_start  = 1'b1;
    i_mem_op = op;
    i_funct3 = f3;
    i_addr   = a;
    i_wdata  = d;
  endtask

  initial begin
    rst_n        = 1'b0;
    i_start      = 1'b0;
    i_mem_op     = MEM_NONE;
    i_funct3     = 3'b000;
    i_addr       = 32'h0;
    i_wdata      = 32'h0;
    bus.wb_dat_i = 32'h0;
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(o_busy), 32'h0);
    chk("rst_done",  32'(o_done), 32'h0);
    chk("rst_cyc",   32'(bus.wb_cyc_o), 32'h0);
    chk("rst_stb",   32'(bus.wb_stb_o), 32'h0);
    chk("rst_we",    32'(bus.wb_we_o), 32'h0);
    chk("rst_adr",   bus.wb_adr_o, 32'h0);
    chk("rst_dat",   bus.wb_dat_o, 32'h0);
    chk("rst_sel",   32'(bus.wb_sel_o), 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_fault", 32'(o_fault), 32'(FAULT_NONE));
    rst_n = 1'b1;
    @(negedge clk);

    // Signed byte load from lane 3, ack one cycle after cyc -> done at T+3
    launch(LOAD_DATA, F3_LB, 32'h0000_1003, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    chk("lb_cyc",  32'(bus.wb_cyc_o), 32'h1);
    chk("lb_stb",  32'(bus.wb_stb_o), 32'h1);
    chk("lb_busy", 32'(o_busy), 32'h1);
    chk("lb_sel",  32'(bus.wb_sel_o), 32'h8);
    chk("lb_adr",  bus.wb_adr_o, 32'h0000_1000);
    chk("lb_we",   32'(bus.wb_we_o), 32'h0);
    @(negedge clk);
    chk("lb_hold_cyc",  32'(bus.wb_cyc_o), 32'h1);
    chk("lb_early_done", 32'(o_done), 32'h0);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h8012_3456;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("lb_done",  32'(o_done), 32'h1);
    chk("lb_busy0", 32'(o_busy), 32'h0);
    chk("lb_cyc0",  32'(bus.wb_cyc_o), 32'h0);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    chk("lb_fault", 32'(o_fault), 32'(FAULT_NONE));
    @(negedge clk);
    chk("lb_done_pulse", 32'(o_done), 32'h0);
    chk("lb_rdata_held", o_rdata, 32'hFFFF_FF80);

    // Unsigned upper halfword, minimum latency (ack in first bus cycle)
    launch(LOAD_DATA, F3_LHU, 32'h0000_2002, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    chk("lhu_sel", 32'(bus.wb_sel_o), 32'hC);
    chk("lhu_adr", bus.wb_adr_o, 32'h0000_2000);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'hBEEF_1234;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("lhu_done",  32'(o_done), 32'h1);
    chk("lhu_rdata", o_rdata, 32'h0000_BEEF);
    chk("lhu_fault", 32'(o_fault), 32'(FAULT_NONE));
    @(negedge clk);

    // Slave never responds: cyc held exactly 4 cycles, then FAULT_TIMEOUT
    launch(LOAD_DATA, F3_LW, 32'h0000_0200, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_cyc%0d", i), 32'(bus.wb_cyc_o), 32'h1);
      chk($sformatf("to_nodone%0d", i), 32'(o_done), 32'h0);
      @(negedge clk);
    end
    chk("to_cyc_drop", 32'(bus.wb_cyc_o), 32'h0);
    chk("to_done",     32'(o_done), 32'h1);
    chk("to_fault",    32'(o_fault), 32'(FAULT_TIMEOUT));
    chk("to_rdata",    o_rdata, 32'h0);
    @(negedge clk);

    // Halfword store at offset 0: lane replication
    launch(STORE_DATA, F3_LH, 32'h0000_0010, 32'h0000_ABCD);
    @(negedge clk);
    i_start = 1'b0;
    chk("sh_we",  32'(bus.wb_we_o), 32'h1);
    chk("sh_sel", 32'(bus.wb_sel_o), 32'h3);
    chk("sh_dat", bus.wb_dat_o, 32'hABCD_ABCD);
    chk("sh_adr", bus.wb_adr_o, 32'h0000_0010);
    bus.wb_ack_i = 1'b1;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("sh_done",  32'(o_done), 32'h1);
    chk("sh_fault", 32'(o_fault), 32'(FAULT_NONE));
    @(negedge clk);

    // ack and err together: err wins; a start during RESP is ignored
    launch(LOAD_DATA, F3_LW, 32'h0000_0300, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    bus.wb_ack_i = 1'b1;
    bus.wb_err_i = 1'b1;
    bus.wb_dat_i = 32'h1234_5678;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    chk("err_done",  32'(o_done), 32'h1);
    chk("err_fault", 32'(o_fault), 32'(FAULT_BUS));
    chk("err_rdata", o_rdata, 32'h0);
    launch(LOAD_DATA, F3_LW, 32'h0000_0400, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    chk("resp_start_busy", 32'(o_busy), 32'h0);
    chk("resp_start_cyc",  32'(bus.wb_cyc_o), 32'h0);
    chk("resp_start_done", 32'(o_done), 32'h0);
    @(negedge clk);
    chk("resp_start_cyc2", 32'(bus.wb_cyc_o), 32'h0);

    // MEM_NONE: done next cycle, no bus cycle
    launch(MEM_NONE, F3_LW, 32'h0000_0500, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    chk("none_done",  32'(o_done), 32'h1);
    chk("none_cyc",   32'(bus.wb_cyc_o), 32'h0);
    chk("none_fault", 32'(o_fault), 32'(FAULT_NONE));
    @(negedge clk);
    chk("none_pulse", 32'(o_done), 32'h0);

    // Illegal funct3 011: no bus cycle, FAULT_MISALIGN
    launch(LOAD_DATA, 3'b011, 32'h0000_0600, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    chk("ill_done",  32'(o_done), 32'h1);
    chk("ill_cyc",   32'(bus.wb_cyc_o), 32'h0);
    chk("ill_fault", 32'(o_fault), 32'(FAULT_MISALIGN));
    @(negedge clk);

    // Misaligned word load at 0x102
    launch(LOAD_DATA, F3_LW, 32'h0000_0102, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_cyc",   32'(bus.wb_cyc_o), 32'h0);
    chk("mis_done",  32'(o_done), 32'h1);
    chk("mis_fault", 32'(o_fault), 32'(FAULT_MISALIGN));
    chk("mis_rdata", o_rdata, 32'h0);
`else
    chk("mis_cyc", 32'(bus.wb_cyc_o), 32'h1);
    chk("mis_adr", bus.wb_adr_o, 32'h0000_0100);
    chk("mis_sel", 32'(bus.wb_sel_o), 32'hF);
    bus.wb_ack_i = 1'b1;
    bus.wb_dat_i = 32'h1122_3344;
    @(negedge clk);
    bus.wb_ack_i = 1'b0;
    chk("mis_done",  32'(o_done), 32'h1);
    chk("mis_fault", 32'(o_fault), 32'(FAULT_NONE));
    chk("mis_rdata", o_rdata, 32'h1122_3344);
`endif
    @(negedge clk);

    // Reset mid-BUS: cycle abandoned at once, no done afterwards
    launch(LOAD_DATA, F3_LW, 32'h0000_0700, 32'h0);
    @(negedge clk);
    i_start = 1'b0;
    chk("mid_cyc", 32'(bus.wb_cyc_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cyc",  32'(bus.wb_cyc_o), 32'h0);
    chk("mid_rst_busy", 32'(o_busy), 32'h0);
    chk("mid_rst_done", 32'(o_done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_done%0d", i), 32'(o_done), 32'h0);
      chk($sformatf("post_rst_cyc%0d", i), 32'(bus.wb_cyc_o), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
